// File: rtl/jpeg_buf_pkg.sv
// Shared types and constants for the JPEG image buffer: capture state,
// byte-lane ordering of stored words and default capacity.
package jpeg_buf_pkg;

   // Capture/readout state of the image buffer
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_READY   = 2'd2
   } buf_state_e;

   // Byte 0 of a stored word is its most significant byte
   localparam logic LANE_MSB_FIRST = 1'b1;

   // Default buffer depth in 32-bit words and byte-address width
   localparam int DEF_BUF_WORDS = 16384;
   localparam int DEF_AW        = 16;

   // Extract the byte at position 'lane' of a stored word, honouring lane order
   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
      logic [1:0] pos;
      if (LANE_MSB_FIRST) begin
         pos = 2'd3 - lane;
      end else begin
         pos = lane;
      end
      case (pos)
         2'd0:    return word[7:0];
         2'd1:    return word[15:8];
         2'd2:    return word[23:16];
         2'd3:    return word[31:24];
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/jpeg_buf_ram.sv
// Simple dual-port image RAM: one write port, one synchronous read port with
// a single cycle of read latency. No reset so it maps onto block RAM.
module jpeg_buf_ram
   import jpeg_buf_pkg::*;
#(
   parameter int DEPTH = DEF_BUF_WORDS,
   parameter int WAW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we_i,
   input  logic [WAW-1:0]  waddr_i,
   input  logic [31:0]     wdata_i,
   input  logic            re_i,
   input  logic [WAW-1:0]  raddr_i,
   output logic [31:0]     rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Write port: store the incoming word when enabled
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port: registered read, output holds between reads
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_image_buffer.sv
// JPEG encoder output buffer: captures compressed words into on-chip RAM,
// latches the final image size and streams the image back byte by byte.
module jpeg_image_buffer
   import jpeg_buf_pkg::*;
#(
   parameter int BUF_WORDS = DEF_BUF_WORDS,
   parameter int AW        = DEF_AW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start_in,
   input  logic [31:0]   in_data,
   input  logic [AW-1:0] in_address,
   input  logic          in_valid,
   input  logic          image_valid_in,
   input  logic          rd_start_in,
   input  logic          rd_req_in,
   output logic [7:0]    rd_data_out,
   output logic          rd_valid_out,
   output logic          image_ready_out,
   output logic [AW:0]   image_size_out,
   output logic          overflow_out
);

   localparam int          WAW       = $clog2(BUF_WORDS);
   localparam logic [AW:0] CAP_BYTES = (AW+1)'(4 * BUF_WORDS);

   buf_state_e  state_q, state_d;
   logic        ivi_prev_q;
   logic [AW:0] size_q, size_d;
   logic        ovf_q, ovf_d;
   logic [AW:0] ptr_q, ptr_d;
   logic        rd_valid_q, rd_valid_d;
   logic        rd_zero_q, rd_zero_d;
   logic [1:0]  lane_q, lane_d;

   logic [AW:0]    addr_ext_s;
   logic [AW:0]    rd_ptr_eff_s;
   logic           ram_we_s;
   logic           ram_re_s;
   logic [WAW-1:0] ram_waddr_s;
   logic [WAW-1:0] ram_raddr_s;
   logic [31:0]    ram_rdata_s;

   assign addr_ext_s = {1'b0, in_address};

   // Next-state logic: capture writes, completion latch, read sequencing
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      ovf_d       = ovf_q;
      ptr_d       = ptr_q;
      rd_valid_d  = 1'b0;
      rd_zero_d   = 1'b0;
      lane_d      = lane_q;
      ram_we_s    = 1'b0;
      ram_re_s    = 1'b0;
      ram_waddr_s = in_address[2 +: WAW];

      // A rewind applies to a request in the same cycle
      if (rd_start_in) begin
         rd_ptr_eff_s = {(AW+1){1'b0}};
      end else begin
         rd_ptr_eff_s = ptr_q;
      end
      ram_raddr_s = rd_ptr_eff_s[2 +: WAW];

      if (start_in) begin
         // Arming a new capture overrides everything else this cycle
         state_d = ST_CAPTURE;
         size_d  = {(AW+1){1'b0}};
         ovf_d   = 1'b0;
         ptr_d   = {(AW+1){1'b0}};
      end else begin
         ptr_d = rd_ptr_eff_s;
         case (state_q)
            ST_CAPTURE: begin
               if (in_valid) begin
                  if ((in_address[1:0] != 2'b00) || (addr_ext_s >= CAP_BYTES)) begin
                     ovf_d = 1'b1;
                  end else begin
                     ram_we_s = 1'b1;
                  end
               end else begin
                  ram_we_s = 1'b0;
               end
               // Completion: the write above (if any) still lands this cycle
               if (image_valid_in && !ivi_prev_q) begin
                  state_d = ST_READY;
                  if (addr_ext_s > CAP_BYTES) begin
                     size_d = CAP_BYTES;
                     ovf_d  = 1'b1;
                  end else begin
                     size_d = addr_ext_s;
                  end
               end else begin
                  state_d = ST_CAPTURE;
               end
            end
            ST_READY: begin
               if (rd_req_in) begin
                  rd_valid_d = 1'b1;
                  if (rd_ptr_eff_s < size_q) begin
                     ram_re_s = 1'b1;
                     lane_d   = rd_ptr_eff_s[1:0];
                     ptr_d    = rd_ptr_eff_s + (AW+1)'(1);
                  end else begin
                     // Past the end of the image: answer with zero, no wrap
                     rd_zero_d = 1'b1;
                  end
               end else begin
                  rd_valid_d = 1'b0;
               end
            end
            ST_EMPTY: begin
               state_d = ST_EMPTY;
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and status registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_EMPTY;
         ivi_prev_q <= 1'b0;
         size_q     <= {(AW+1){1'b0}};
         ovf_q      <= 1'b0;
         ptr_q      <= {(AW+1){1'b0}};
         rd_valid_q <= 1'b0;
         rd_zero_q  <= 1'b0;
         lane_q     <= 2'b00;
      end else begin
         state_q    <= state_d;
         ivi_prev_q <= image_valid_in;
         size_q     <= size_d;
         ovf_q      <= ovf_d;
         ptr_q      <= ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_zero_q  <= rd_zero_d;
         lane_q     <= lane_d;
      end
   end

   jpeg_buf_ram #(
      .DEPTH (BUF_WORDS),
      .WAW   (WAW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we_s),
      .waddr_i (ram_waddr_s),
      .wdata_i (in_data),
      .re_i    (ram_re_s),
      .raddr_i (ram_raddr_s),
      .rdata_o (ram_rdata_s)
   );

   // Byte returned for the request of the previous cycle; zero when idle or past end
   assign rd_data_out     = (rd_valid_q && !rd_zero_q) ? lane_byte(ram_rdata_s, lane_q) : 8'h00;
   assign rd_valid_out    = rd_valid_q;
   assign image_ready_out = (state_q == ST_READY);
   assign image_size_out  = size_q;
   assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_jpeg_image_buffer.sv
// Bench for jpeg_image_buffer: directed scenarios plus randomized capture/read
// sessions checked against a byte-array reference model.
module tb_jpeg_image_buffer;

   localparam int BW  = 1024;
   localparam int AWP = 16;
   localparam int CAP = 4 * BW;

   logic           clk = 1'b0;
   logic           resetn;
   logic           start_in;
   logic [31:0]    in_data;
   logic [AWP-1:0] in_address;
   logic           in_valid;
   logic           image_valid_in;
   logic           rd_start_in;
   logic           rd_req_in;
   logic [7:0]     rd_data_out;
   logic           rd_valid_out;
   logic           image_ready_out;
   logic [AWP:0]   image_size_out;
   logic           overflow_out;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [7:0] m_mem   [CAP];
   bit         m_known [CAP];
   int         m_mode;   // 0 empty, 1 capturing, 2 image held
   int         m_size;
   int         m_ptr;
   bit         m_ovf;
   bit         m_prev;
   bit         e_valid;
   bit         e_chk;
   logic [7:0] e_data;

   jpeg_image_buffer #(.BUF_WORDS(BW), .AW(AWP)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .start_in        (start_in),
      .in_data         (in_data),
      .in_address      (in_address),
      .in_valid        (in_valid),
      .image_valid_in  (image_valid_in),
      .rd_start_in     (rd_start_in),
      .rd_req_in       (rd_req_in),
      .rd_data_out     (rd_data_out),
      .rd_valid_out    (rd_valid_out),
      .image_ready_out (image_ready_out),
      .image_size_out  (image_size_out),
      .overflow_out    (overflow_out)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode = 0; m_size = 0; m_ptr = 0; m_ovf = 1'b0; m_prev = 1'b0;
      e_valid = 1'b0; e_chk = 1'b0; e_data = 8'h00;
   endtask

   // drive one cycle of inputs, advance the model, sample 1 time unit after the edge
   task automatic step(input bit st, input bit iv, input int addr, input logic [31:0] d,
                       input bit ivi, input bit rds, input bit rdr);
      start_in = st; in_valid = iv; in_address = 16'(addr); in_data = d;
      image_valid_in = ivi; rd_start_in = rds; rd_req_in = rdr;
      e_valid = 1'b0; e_chk = 1'b0; e_data = 8'h00;
      if (st) begin
         m_mode = 1; m_size = 0; m_ovf = 1'b0; m_ptr = 0;
      end else begin
         if (rds) m_ptr = 0;
         if (m_mode == 1) begin
            if (iv) begin
               if ((addr % 4) != 0 || addr >= CAP) m_ovf = 1'b1;
               else for (int k = 0; k < 4; k++) begin
                  m_mem[addr + k]   = d[8*(3-k) +: 8];
                  m_known[addr + k] = 1'b1;
               end
            end
            if (ivi && !m_prev) begin
               m_mode = 2;
               m_size = (addr > CAP) ? CAP : addr;
               if (addr > CAP) m_ovf = 1'b1;
            end
         end else if (m_mode == 2 && rdr) begin
            e_valid = 1'b1;
            if (m_ptr < m_size) begin
               e_data = m_mem[m_ptr]; e_chk = m_known[m_ptr]; m_ptr++;
            end else begin
               e_data = 8'h00; e_chk = 1'b1;
            end
         end
      end
      m_prev = ivi;
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      start_in = 1'b0; in_valid = 1'b0; in_address = '0; in_data = '0;
      image_valid_in = 1'b0; rd_start_in = 1'b0; rd_req_in = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #3;
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if (rd_valid_out !== 1'b0 || rd_data_out !== 8'h00 || image_ready_out !== 1'b0 ||
          image_size_out !== 17'd0 || overflow_out !== 1'b0) begin
         bad++;
         $display("FAIL reset: got v=%b d=%h rdy=%b size=%0d ovf=%b want all zero",
                  rd_valid_out, rd_data_out, image_ready_out, image_size_out, overflow_out);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_b [6];
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 32'h11223344, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4, 32'h55667788, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 6, 32'h0, 1'b1, 1'b0, 1'b0);
      total++;
      if (image_ready_out !== 1'b1 || image_size_out !== 17'd6) begin
         bad++;
         $display("FAIL basic_done: got rdy=%b size=%0d want rdy=1 size=6", image_ready_out, image_size_out);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 0, 32'h0, 1'b1, (i == 0), 1'b1);
         total++;
         if (rd_valid_out !== 1'b1 || rd_data_out !== exp_b[i]) begin
            bad++;
            $display("FAIL basic_rd%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid_out, rd_data_out, exp_b[i]);
         end
      end
   endtask

   task automatic test_past_end();
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b1);
         total++;
         if (rd_valid_out !== 1'b1 || rd_data_out !== 8'h00) begin
            bad++;
            $display("FAIL past_end%0d: got v=%b d=%h want v=1 d=00", i, rd_valid_out, rd_data_out);
         end
      end
      step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      total++;
      if (rd_valid_out !== 1'b0 || image_size_out !== 17'd6) begin
         bad++;
         $display("FAIL past_end_idle: got v=%b size=%0d want v=0 size=6", rd_valid_out, image_size_out);
      end
      step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 1'b1);
      total++;
      if (rd_valid_out !== 1'b1 || rd_data_out !== 8'h11) begin
         bad++;
         $display("FAIL rewind: got v=%b d=%h want v=1 d=11", rd_valid_out, rd_data_out);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_b [4];
      exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      total++;
      if (overflow_out !== 1'b1) begin
         bad++;
         $display("FAIL ovf_misaligned: got ovf=%b want 1", overflow_out);
      end
      step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      total++;
      if (overflow_out !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear: got ovf=%b want 0", overflow_out);
      end
      step(1'b0, 1'b1, CAP, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
      total++;
      if (overflow_out !== 1'b1) begin
         bad++;
         $display("FAIL ovf_range: got ovf=%b want 1", overflow_out);
      end
      step(1'b0, 1'b0, 4, 32'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 0, 32'h0, 1'b0, (i == 0), 1'b1);
         total++;
         if (rd_valid_out !== 1'b1 || rd_data_out !== exp_b[i] || overflow_out !== 1'b1) begin
            bad++;
            $display("FAIL ovf_rd%0d: got v=%b d=%h ovf=%b want v=1 d=%h ovf=1",
                     i, rd_valid_out, rd_data_out, overflow_out, exp_b[i]);
         end
      end
   endtask

   task automatic test_ignored();
      logic [7:0] exp_b [4];
      exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      apply_reset();
      step(1'b0, 1'b1, 0, 32'h0BADBEEF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
         total++;
         if (rd_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL rd_in_capture%0d: got v=%b want 0", i, rd_valid_out);
         end
      end
      step(1'b0, 1'b0, 4, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 32'h0BADF00D, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 0, 32'h0, 1'b1, (i == 0), 1'b1);
         total++;
         if (rd_valid_out !== 1'b1 || rd_data_out !== exp_b[i] || overflow_out !== 1'b0) begin
            bad++;
            $display("FAIL ignored_rd%0d: got v=%b d=%h ovf=%b want v=1 d=%h ovf=0",
                     i, rd_valid_out, rd_data_out, overflow_out, exp_b[i]);
         end
      end
   endtask

   task automatic test_start_during_read();
      step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
      total++;
      if (rd_valid_out !== 1'b0 || image_size_out !== 17'd0 || overflow_out !== 1'b0 ||
          image_ready_out !== 1'b0) begin
         bad++;
         $display("FAIL start_wins: got v=%b size=%0d ovf=%b rdy=%b want 0 0 0 0",
                  rd_valid_out, image_size_out, overflow_out, image_ready_out);
      end
      step(1'b0, 1'b1, 0, 32'h99887766, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 1'b1);
      total++;
      if (rd_valid_out !== 1'b1 || rd_data_out !== 8'h99 || image_size_out !== 17'd4) begin
         bad++;
         $display("FAIL start_capture: got v=%b d=%h size=%0d want v=1 d=99 size=4",
                  rd_valid_out, rd_data_out, image_size_out);
      end
   endtask

   task automatic test_reset_mid_read();
      step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 32'h01020304, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b1);
      total++;
      if (rd_valid_out !== 1'b1 || rd_data_out !== 8'h02) begin
         bad++;
         $display("FAIL mid_pre: got v=%b d=%h want v=1 d=02", rd_valid_out, rd_data_out);
      end
      #3 resetn = 1'b0;
      #1;
      total++;
      if (rd_valid_out !== 1'b0 || rd_data_out !== 8'h00 || image_ready_out !== 1'b0 ||
          image_size_out !== 17'd0 || overflow_out !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got v=%b d=%h rdy=%b size=%0d ovf=%b want all zero",
                  rd_valid_out, rd_data_out, image_ready_out, image_size_out, overflow_out);
      end
      @(posedge clk); #3;
      resetn = 1'b1;
      model_reset();
      step(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
      total++;
      if (rd_valid_out !== 1'b0 || image_ready_out !== 1'b0 || image_size_out !== 17'd0) begin
         bad++;
         $display("FAIL post_reset: got v=%b rdy=%b size=%0d want 0 0 0",
                  rd_valid_out, image_ready_out, image_size_out);
      end
   endtask

   task automatic test_random();
      int addr;
      int r;
      int nw;
      for (int it = 0; it < 25; it++) begin
         step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
         nw = $urandom_range(10, 30);
         for (int w = 0; w < nw + 44; w++) begin
            bit iv, ivi, rds, rdr;
            r = $urandom_range(0, 99);
            if (r < 70)      addr = 4 * $urandom_range(0, 63);
            else if (r < 85) addr = 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
            else             addr = $urandom_range(CAP, 65535);
            iv  = ($urandom_range(0, 3) != 0);
            ivi = 1'b0;
            rdr = ($urandom_range(0, 4) != 0);
            rds = ($urandom_range(0, 9) == 0);
            if (w == nw) begin
               ivi = 1'b1;
               addr = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 260) : $urandom_range(CAP - 8, 65535);
            end else if (w > nw && w < nw + 4) begin
               ivi = 1'b1;
            end
            step(1'b0, iv, addr, $urandom, ivi, rds, rdr);
            total++;
            if (rd_valid_out !== e_valid || (e_valid && e_chk && rd_data_out !== e_data)) begin
               bad++;
               $display("FAIL rand_rd it=%0d c=%0d: got v=%b d=%h want v=%b d=%h",
                        it, w, rd_valid_out, rd_data_out, e_valid, e_data);
            end
            total++;
            if (image_size_out !== 17'(m_size) || image_ready_out !== (m_mode == 2) ||
                overflow_out !== m_ovf) begin
               bad++;
               $display("FAIL rand_status it=%0d c=%0d: got size=%0d rdy=%b ovf=%b want size=%0d rdy=%b ovf=%b",
                        it, w, image_size_out, image_ready_out, overflow_out, m_size, (m_mode == 2), m_ovf);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < CAP; i++) m_known[i] = 1'b0;
      test_reset();
      test_basic();
      test_past_end();
      test_overflow();
      test_ignored();
      test_start_during_read();
      test_reset_mid_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jpeg_image_buffer.md
Name: jpeg_image_buffer

Overview:
- Receiving end of the JPEG encoder output stream: accepts 32-bit compressed words with their byte addresses, stores them in an on-chip image buffer RAM, and latches the final image size when the encoder signals completion.
- Presents the stored bitstream to the host-side reader (SPI register interface) as a sequential byte stream with a request/valid handshake.
- Sits between the encoder top level and the SPI peripheral, in the same clock domain as the encoder output.

Parameters:
- BUF_WORDS, 16384, depth of the image buffer in 32-bit words (capacity = 4*BUF_WORDS bytes).
- AW, 16, width of the byte address (must satisfy 2^AW >= 4*BUF_WORDS).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_in  in  1  single-cycle pulse; arms a new capture.
- in_data  in  32  compressed data word; byte 0 of the word is in_data[31:24].
- in_address  in  AW  byte address of in_data; a multiple of 4.
- in_valid  in  1  qualifies in_data/in_address.
- image_valid_in  in  1  level; encoder finished. On its rising edge, in_address holds the total size in bytes.
- rd_start_in  in  1  pulse; rewinds the read pointer to byte 0.
- rd_req_in  in  1  request the next byte.
- rd_data_out  out  8  byte read data.
- rd_valid_out  out  1  qualifies rd_data_out.
- image_ready_out  out  1  high while the buffer holds a complete image.
- image_size_out  out  AW+1  latched image size in bytes.
- overflow_out  out  1  sticky; a write beyond capacity or misaligned was dropped.

Behaviour:
- States: EMPTY, CAPTURE, READY. Reset value is EMPTY. Outputs on reset: rd_data_out=0, rd_valid_out=0, image_ready_out=0, image_size_out=0, overflow_out=0. Read pointer resets to 0.
- State transitions:
  - start_in in any state -> CAPTURE. This clears image_size_out, overflow_out, the read pointer and rd_valid_out (next cycle). RAM contents are not cleared.
  - CAPTURE and a rising edge of image_valid_in (registered previous value) -> READY. Latches image_size_out = min(in_address, 4*BUF_WORDS); if in_address exceeds capacity, overflow_out is set.
  - READY stays READY until the next start_in.
- Writes:
  - Performed only in CAPTURE with in_valid=1, to word in_address[AW-1:2].
  - in_address[1:0]!=0, or in_address[AW-1:2] >= BUF_WORDS -> write dropped, overflow_out set.
  - Writes outside CAPTURE are ignored silently.
- Simultaneous events:
  - in_valid together with the image_valid_in rising edge: the write is performed, then the block enters READY.
  - start_in wins over every other input in the same cycle.
- Reads:
  - Accepted only in READY.
  - rd_req_in=1 -> synchronous RAM read of word ptr[AW-1:2], byte lane ptr[1:0] (lane 0 = bits 31:24).
  - rd_valid_out=1 exactly one cycle after the request, with rd_data_out = that byte; the pointer then increments.
  - Back-to-back requests every cycle are supported (throughput 1 byte/cycle).
  - Request with ptr >= image_size_out -> rd_valid_out=1, rd_data_out=8'h00, pointer holds (no wrap).
  - rd_req_in outside READY -> ignored, rd_valid_out=0.
  - rd_start_in -> pointer=0 next cycle; if it coincides with rd_req_in, that request reads byte 0.
- Read/write collision cannot occur: writes are only in CAPTURE and reads only in READY.
- resetn asserted mid-capture or mid-read -> immediate return to EMPTY with all outputs at reset values.

Decomposition:
- Package jpeg_buf_pkg holds:
  - state enum {EMPTY, CAPTURE, READY};
  - byte-lane order constant (MSB-first);
  - default capacity localparams.
- Sub-module jpeg_buf_ram: simple dual-port, 32-bit wide, BUF_WORDS deep, one write port and one synchronous read port with 1-cycle latency. Infers EBR/LRAM.

Test Plan:
1. Reset, start_in, write words 0x11223344@0 and 0x55667788@4, raise image_valid_in with in_address=6, rd_start_in, 6 back-to-back rd_req_in -> bytes 11,22,33,44,55,66 each 1 cycle after request; image_size_out=6; image_ready_out=1.
2. Continue from scenario 1 with 2 extra rd_req_in -> rd_valid_out=1, rd_data_out=00 both times; pointer stays at 6.
3. In CAPTURE, write with in_address=0x0002, then with in_address >= 4*BUF_WORDS -> overflow_out=1; neither write changes the RAM (verify by reading back word 0).
4. in_valid in EMPTY and in READY -> no RAM change; rd_req_in in CAPTURE -> rd_valid_out stays 0.
5. start_in in the same cycle as rd_req_in while in READY -> next cycle state=CAPTURE, rd_valid_out=0, image_size_out=0, overflow_out=0.
6. resetn low during a read burst (asynchronous, mid-cycle) -> rd_valid_out, image_ready_out and image_size_out go to 0 immediately; state=EMPTY after release.
